// File: rtl/csr_reg_file_unit_pkg.sv
// Shared definitions for the M-mode CSR file: addresses, bit positions and
// the write-data mux op codes.
package csr_reg_file_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned IRQ_MEI_BIT      = 11;
    localparam int unsigned IRQ_MTI_BIT      = 7;
    localparam int unsigned IRQ_MSI_BIT      = 3;

    typedef enum logic [1:0] {CSR_NOP, CSR_RW, CSR_RS, CSR_RC} csr_op_e;

    // Packs the three machine interrupt bits into mie/mip layout.
    function automatic logic [31:0] irq_word(input logic mei, input logic mti, input logic msi);
        logic [31:0] w;
        w = '0;
        w[IRQ_MEI_BIT] = mei;
        w[IRQ_MTI_BIT] = mti;
        w[IRQ_MSI_BIT] = msi;
        return w;
    endfunction

endpackage

// File: rtl/csr_counter_unit.sv
// 64-bit counter with increment enable and independently writable halves.
module csr_counter_unit (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        inc_en_in,
    input  logic        wr_lo_in,
    input  logic        wr_hi_in,
    input  logic [31:0] wr_data_in,
    output logic [63:0] count_out
);

    logic [31:0] lo_q, lo_d, hi_q, hi_d;
    logic        carry;

    always_comb begin
        carry = inc_en_in & (&lo_q);
        lo_d  = wr_lo_in ? wr_data_in : lo_q + {31'b0, inc_en_in};
        // A low-half write swallows the carry; a high-half write overrides it.
        hi_d  = wr_hi_in ? wr_data_in : hi_q + {31'b0, carry & ~wr_lo_in};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign count_out = {hi_q, lo_q};

endmodule

// File: rtl/csr_reg_file_unit.sv
// Machine-mode CSR register file: trap/interrupt CSRs, counters, trap entry
// and MRET handling, and trap/return targets for fetch.
module csr_reg_file_unit
    import csr_reg_file_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [11:0] csr_addr_in,
    input  logic        wr_en_in,
    input  logic [31:0] data_wr_in,
    output logic [31:0] csr_data_out,
    output logic        illegal_csr_out,
    input  logic        trap_taken_in,
    input  logic [31:0] cause_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] tval_in,
    input  logic        mret_in,
    input  logic        instret_inc_in,
    input  logic        e_irq_in,
    input  logic        t_irq_in,
    input  logic        s_irq_in,
    output logic [31:0] trap_address_out,
    output logic [31:0] epc_out,
    output logic        irq_pending_out
);

    logic        mie_bit_q, mie_bit_d, mpie_q, mpie_d;
    logic [2:0]  irq_en_q, irq_en_d, irq_pend_q;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0] mcycle, minstret;
    logic        implemented, wr_ok;
    logic [31:0] mtvec_base;

    always_comb begin
        implemented = 1'b1;
        csr_data_out = '0;
        case (csr_addr_in)
            CSR_MSTATUS: begin
                csr_data_out = 32'h0000_1800;
                csr_data_out[MSTATUS_MIE_BIT]  = mie_bit_q;
                csr_data_out[MSTATUS_MPIE_BIT] = mpie_q;
            end
            CSR_MISA:                 csr_data_out = MISA_VALUE;
            CSR_MIE:                  csr_data_out = irq_word(irq_en_q[2], irq_en_q[1], irq_en_q[0]);
            CSR_MTVEC:                csr_data_out = mtvec_q & 32'hFFFF_FFFD;
            CSR_MSCRATCH:             csr_data_out = mscratch_q;
            CSR_MEPC:                 csr_data_out = mepc_q & 32'hFFFF_FFFC;
            CSR_MCAUSE:               csr_data_out = mcause_q;
            CSR_MTVAL:                csr_data_out = mtval_q;
            CSR_MIP:                  csr_data_out = irq_word(irq_pend_q[2], irq_pend_q[1],
                                                              irq_pend_q[0]);
            CSR_MCYCLE, CSR_CYCLE:    csr_data_out = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:  csr_data_out = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   csr_data_out = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr_data_out = minstret[63:32];
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_data_out = '0;
            CSR_MHARTID:              csr_data_out = HART_ID;
            default:                  implemented = 1'b0;
        endcase
    end

    assign wr_ok           = wr_en_in & implemented & (csr_addr_in[11:10] != 2'b11);
    assign illegal_csr_out = ~implemented | (wr_en_in & (csr_addr_in[11:10] == 2'b11));

    always_comb begin
        mie_bit_d  = mie_bit_q;
        mpie_d     = mpie_q;
        irq_en_d   = irq_en_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (wr_ok) begin
            case (csr_addr_in)
                CSR_MSTATUS: begin
                    mie_bit_d = data_wr_in[MSTATUS_MIE_BIT];
                    mpie_d    = data_wr_in[MSTATUS_MPIE_BIT];
                end
                CSR_MIE: irq_en_d = {data_wr_in[IRQ_MEI_BIT], data_wr_in[IRQ_MTI_BIT],
                                     data_wr_in[IRQ_MSI_BIT]};
                CSR_MTVEC:    mtvec_d    = data_wr_in;
                CSR_MSCRATCH: mscratch_d = data_wr_in;
                CSR_MEPC:     mepc_d     = data_wr_in;
                CSR_MCAUSE:   mcause_d   = data_wr_in;
                CSR_MTVAL:    mtval_d    = data_wr_in;
                default: ;
            endcase
        end
        // Trap entry and MRET override any software write to the same CSRs.
        if (trap_taken_in) begin
            mepc_d    = pc_in;
            mcause_d  = cause_in;
            mtval_d   = tval_in;
            mpie_d    = mie_bit_q;
            mie_bit_d = 1'b0;
        end else if (mret_in) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mie_bit_q  <= 1'b0;
            mpie_q     <= 1'b0;
            irq_en_q   <= '0;
            irq_pend_q <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mie_bit_q  <= mie_bit_d;
            mpie_q     <= mpie_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= {e_irq_in, t_irq_in, s_irq_in};
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    csr_counter_unit u_mcycle (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .inc_en_in  (1'b1),
        .wr_lo_in   (wr_ok & (csr_addr_in == CSR_MCYCLE)),
        .wr_hi_in   (wr_ok & (csr_addr_in == CSR_MCYCLEH)),
        .wr_data_in (data_wr_in),
        .count_out  (mcycle)
    );

    csr_counter_unit u_minstret (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .inc_en_in  (instret_inc_in),
        .wr_lo_in   (wr_ok & (csr_addr_in == CSR_MINSTRET)),
        .wr_hi_in   (wr_ok & (csr_addr_in == CSR_MINSTRETH)),
        .wr_data_in (data_wr_in),
        .count_out  (minstret)
    );

    assign mtvec_base       = {mtvec_q[31:2], 2'b00};
    assign trap_address_out = (mtvec_q[0] & cause_in[31])
                            ? mtvec_base + {25'b0, cause_in[4:0], 2'b00} : mtvec_base;
    assign epc_out          = {mepc_q[31:2], 2'b00};
    assign irq_pending_out  = mie_bit_q & |(irq_en_q & irq_pend_q);

endmodule

// File: tb/tb_csr_reg_file_unit.sv
// Directed bench for csr_reg_file_unit: a read/write vector table plus
// hand sequences for counters, traps, MRET and asynchronous reset.
module tb_csr_reg_file_unit;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [11:0] csr_addr_in = '0;
    logic        wr_en_in = 1'b0;
    logic [31:0] data_wr_in = '0;
    logic [31:0] csr_data_out;
    logic        illegal_csr_out;
    logic        trap_taken_in = 1'b0;
    logic [31:0] cause_in = '0;
    logic [31:0] pc_in = '0;
    logic [31:0] tval_in = '0;
    logic        mret_in = 1'b0;
    logic        instret_inc_in = 1'b0;
    logic        e_irq_in = 1'b0;
    logic        t_irq_in = 1'b0;
    logic        s_irq_in = 1'b0;
    logic [31:0] trap_address_out;
    logic [31:0] epc_out;
    logic        irq_pending_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    csr_reg_file_unit #(
        .MTVEC_RESET (32'h0000_0000),
        .MISA_VALUE  (32'h4000_0100),
        .HART_ID     (32'h0000_0000)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .csr_addr_in      (csr_addr_in),
        .wr_en_in         (wr_en_in),
        .data_wr_in       (data_wr_in),
        .csr_data_out     (csr_data_out),
        .illegal_csr_out  (illegal_csr_out),
        .trap_taken_in    (trap_taken_in),
        .cause_in         (cause_in),
        .pc_in            (pc_in),
        .tval_in          (tval_in),
        .mret_in          (mret_in),
        .instret_inc_in   (instret_inc_in),
        .e_irq_in         (e_irq_in),
        .t_irq_in         (t_irq_in),
        .s_irq_in         (s_irq_in),
        .trap_address_out (trap_address_out),
        .epc_out          (epc_out),
        .irq_pending_out  (irq_pending_out)
    );

    typedef struct {
        logic [11:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
        csr_addr_in = addr;
        #1;
        chk(name, csr_data_out, exp);
    endtask

    task automatic wr_csr(input logic [11:0] addr, input logic [31:0] data);
        @(negedge clk_in);
        csr_addr_in = addr;
        data_wr_in  = data;
        wr_en_in    = 1'b1;
        @(posedge clk_in);
        #1;
        wr_en_in = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{12'h300, 1'b0, 32'h0,         32'h0000_1800, 1'b0};
        vecs[1]  = '{12'h305, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[2]  = '{12'h301, 1'b0, 32'h0,         32'h4000_0100, 1'b0};
        vecs[3]  = '{12'hF14, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[4]  = '{12'hF11, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[5]  = '{12'h340, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[6]  = '{12'h340, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{12'h305, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[8]  = '{12'h305, 1'b0, 32'h0,         32'hFFFF_FFFD, 1'b0};
        vecs[9]  = '{12'h341, 1'b1, 32'h0000_1237, 32'h0000_0000, 1'b0};
        vecs[10] = '{12'h341, 1'b0, 32'h0,         32'h0000_1234, 1'b0};
        vecs[11] = '{12'h304, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[12] = '{12'h304, 1'b0, 32'h0,         32'h0000_0888, 1'b0};
        vecs[13] = '{12'h300, 1'b1, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0};
        vecs[14] = '{12'h300, 1'b1, 32'h0000_0000, 32'h0000_1888, 1'b0};
        vecs[15] = '{12'h300, 1'b0, 32'h0,         32'h0000_1800, 1'b0};
        vecs[16] = '{12'h344, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[17] = '{12'h344, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[18] = '{12'h7C0, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
        vecs[19] = '{12'h7C0, 1'b1, 32'h1234_5678, 32'h0000_0000, 1'b1};
        vecs[20] = '{12'hF14, 1'b1, 32'h0000_0005, 32'h0000_0000, 1'b1};
        vecs[21] = '{12'hF14, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[22] = '{12'h301, 1'b1, 32'h0000_0000, 32'h4000_0100, 1'b0};
        vecs[23] = '{12'h301, 1'b0, 32'h0,         32'h4000_0100, 1'b0};
        vecs[24] = '{12'h342, 1'b1, 32'h8000_0003, 32'h0000_0000, 1'b0};
        vecs[25] = '{12'h342, 1'b0, 32'h0,         32'h8000_0003, 1'b0};
        vecs[26] = '{12'h343, 1'b1, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[27] = '{12'h343, 1'b0, 32'h0,         32'h1234_5678, 1'b0};

        // Reset values and free-running mcycle after release.
        #2;
        rd_chk("rst_mcycle", 12'hB00, 32'h0);
        chk("rst_irq_pending", {31'b0, irq_pending_out}, 32'h0);
        #9;  // release at t=12, between edges
        rst_in = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;
        rd_chk("mcycle_after_5", 12'hB00, 32'd5);
        rd_chk("cycle_shadow_5", 12'hC00, 32'd5);
        rd_chk("mcycleh_0", 12'hB80, 32'd0);

        for (int i = 0; i < 28; i++) begin
            @(negedge clk_in);
            csr_addr_in = vecs[i].addr;
            wr_en_in    = vecs[i].wr;
            data_wr_in  = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d_data", i), csr_data_out, vecs[i].exp_data);
            chk($sformatf("vec%0d_illegal", i), {31'b0, illegal_csr_out},
                {31'b0, vecs[i].exp_ill});
        end
        @(negedge clk_in);
        wr_en_in = 1'b0;

        // Counter carry and per-half write interactions.
        wr_csr(12'hB80, 32'h0000_0010);
        wr_csr(12'hB00, 32'hFFFF_FFFF);
        rd_chk("lo_written", 12'hB00, 32'hFFFF_FFFF);
        rd_chk("hi_no_carry", 12'hB80, 32'h0000_0010);
        @(posedge clk_in);
        #1;
        rd_chk("lo_wrapped", 12'hB00, 32'h0);
        rd_chk("hi_carried", 12'hB80, 32'h0000_0011);
        wr_csr(12'hB00, 32'hFFFF_FFFF);
        wr_csr(12'hB80, 32'h0000_0077);
        rd_chk("hi_write_wins_lo", 12'hB00, 32'h0);
        rd_chk("hi_write_wins_hi", 12'hB80, 32'h0000_0077);
        wr_csr(12'hB00, 32'd100);
        @(negedge clk_in);
        csr_addr_in = 12'hC00;
        data_wr_in  = 32'h0;
        wr_en_in    = 1'b1;
        #1;
        chk("wr_c00_illegal", {31'b0, illegal_csr_out}, 32'h1);
        chk("wr_c00_data", csr_data_out, 32'd100);
        @(posedge clk_in);
        #1;
        wr_en_in = 1'b0;
        rd_chk("cycle_unchanged", 12'hB00, 32'd101);
        rd_chk("cycleh_shadow", 12'hC80, 32'h0000_0077);

        @(negedge clk_in);
        instret_inc_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        instret_inc_in = 1'b0;
        rd_chk("minstret_3", 12'hB02, 32'd3);
        rd_chk("instret_shadow_3", 12'hC02, 32'd3);
        wr_csr(12'hB82, 32'hFFFF_FFFF);
        wr_csr(12'hB02, 32'hFFFF_FFFF);
        @(negedge clk_in);
        instret_inc_in = 1'b1;
        @(posedge clk_in);
        #1;
        instret_inc_in = 1'b0;
        rd_chk("minstret_wrap_lo", 12'hB02, 32'h0);
        rd_chk("minstret_wrap_hi", 12'hB82, 32'h0);

        // Interrupt pending and vectored trap entry.
        wr_csr(12'h305, 32'h8000_0001);
        wr_csr(12'h304, 32'h0000_0800);
        wr_csr(12'h300, 32'h0000_0008);
        @(negedge clk_in);
        e_irq_in = 1'b1;
        #1;
        chk("irq_latency", {31'b0, irq_pending_out}, 32'h0);
        @(posedge clk_in);
        #1;
        chk("irq_pending", {31'b0, irq_pending_out}, 32'h1);
        rd_chk("mip_meip", 12'h344, 32'h0000_0800);
        cause_in = 32'h0000_0003;
        #1;
        chk("trap_addr_exc", trap_address_out, 32'h8000_0000);
        @(negedge clk_in);
        trap_taken_in = 1'b1;
        cause_in      = 32'h8000_000B;
        pc_in         = 32'h0000_2000;
        tval_in       = 32'h0000_0055;
        #1;
        chk("trap_addr_vec", trap_address_out, 32'h8000_002C);
        @(posedge clk_in);
        #1;
        trap_taken_in = 1'b0;
        e_irq_in      = 1'b0;
        rd_chk("trap_mstatus", 12'h300, 32'h0000_1880);
        chk("trap_irq_off", {31'b0, irq_pending_out}, 32'h0);
        rd_chk("trap_mcause", 12'h342, 32'h8000_000B);
        rd_chk("trap_mtval", 12'h343, 32'h0000_0055);
        chk("trap_epc", epc_out, 32'h0000_2000);

        // Trap and MRET on the same edge: trap wins.
        wr_csr(12'h300, 32'h0000_0088);
        @(negedge clk_in);
        trap_taken_in = 1'b1;
        mret_in       = 1'b1;
        pc_in         = 32'h0000_1003;
        cause_in      = 32'h0000_0002;
        @(posedge clk_in);
        #1;
        trap_taken_in = 1'b0;
        mret_in       = 1'b0;
        rd_chk("trap_vs_mret_mstatus", 12'h300, 32'h0000_1880);
        rd_chk("trap_vs_mret_mepc", 12'h341, 32'h0000_1000);
        @(negedge clk_in);
        mret_in = 1'b1;
        @(posedge clk_in);
        #1;
        mret_in = 1'b0;
        rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);
        chk("mret_epc", epc_out, 32'h0000_1000);

        // Asynchronous reset mid-run.
        e_irq_in = 1'b1;
        @(posedge clk_in);
        #1;
        chk("pre_reset_irq", {31'b0, irq_pending_out}, 32'h1);
        @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_irq", {31'b0, irq_pending_out}, 32'h0);
        chk("async_epc", epc_out, 32'h0);
        rd_chk("async_mcycle", 12'hB00, 32'h0);
        rd_chk("async_mstatus", 12'h300, 32'h0000_1800);
        rd_chk("async_mscratch", 12'h340, 32'h0);
        rd_chk("async_mtvec", 12'h305, 32'h0);
        e_irq_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        rd_chk("restart_mcycle", 12'hB00, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
